// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Elastic pipeline stage register with valid/ready handshake,
//                2-entry skid buffer, flush-to-NOP and a saturating
//                stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
   parameter int                DATA_W   = 118,
   parameter logic [DATA_W-1:0] NOP_DATA = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             r_state;
   logic [DATA_W-1:0]  r_main;
   logic [DATA_W-1:0]  r_skid;
   logic               r_out_valid;
   logic               r_in_ready;
   logic [1:0]         r_occ;
   logic [CNT_W-1:0]   r_stall;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_cnt_max;

   // Handshake qualifiers; both are built only from registered state and the
   // partner's request, so no in->out or out_ready->in_ready path exists.
   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;
   assign w_cnt_max  = &r_stall;

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_data     = r_main;
   assign occupancy    = r_occ;
   assign stall_cycles = r_stall;

   // Entry storage and occupancy FSM; status outputs are registered alongside
   // the state so they change exactly with it. Empty slots always hold NOP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_main      <= NOP_DATA;
         r_skid      <= NOP_DATA;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= 2'd0;
      end else if (flush) begin
         // Squash wins over any same-cycle capture; an out_fire this cycle
         // has already been taken by the downstream stage.
         r_state     <= S_EMPTY;
         r_main      <= NOP_DATA;
         r_skid      <= NOP_DATA;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= 2'd0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  r_main      <= in_data;
                  r_state     <= S_ONE;
                  r_out_valid <= 1'b1;
                  r_occ       <= 2'd1;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main <= in_data;
               end else if (w_out_fire) begin
                  r_main      <= NOP_DATA;
                  r_state     <= S_EMPTY;
                  r_out_valid <= 1'b0;
                  r_occ       <= 2'd0;
               end else if (w_in_fire) begin
                  r_skid     <= in_data;
                  r_state    <= S_FULL;
                  r_in_ready <= 1'b0;
                  r_occ      <= 2'd2;
               end
            end
            S_FULL: begin
               // Skid entry is promoted only after the main entry leaves.
               if (w_out_fire) begin
                  r_main     <= r_skid;
                  r_skid     <= NOP_DATA;
                  r_state    <= S_ONE;
                  r_in_ready <= 1'b1;
                  r_occ      <= 2'd1;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_main      <= NOP_DATA;
               r_skid      <= NOP_DATA;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_occ       <= 2'd0;
            end
         endcase
      end
   end

   // Saturating count of cycles where a valid output is blocked downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (r_out_valid && !out_ready && !flush && !w_cnt_max) begin
         r_stall <= r_stall + c_CNT_ONE;
      end
   end

endmodule
`default_nettype wire
